// File: rtl/issue_scoreboard.sv
// Multi-lane in-order issue stage with a per-register countdown scoreboard.
// Accepts the oldest hazard-free prefix of each decode bundle and registers it.
module issue_scoreboard #(
    parameter int LANES     = 2,
    parameter int NUM_REGS  = 128,
    parameter int ADDR_W    = 7,
    parameter int LAT_W     = 3,
    parameter int PAYLOAD_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             dec_valid,
    input  logic [LANES*3*ADDR_W-1:0]    dec_src_addr,
    input  logic [LANES*3-1:0]           dec_src_used,
    input  logic [LANES*ADDR_W-1:0]      dec_rt_addr,
    input  logic [LANES-1:0]             dec_rt_wr,
    input  logic [LANES*LAT_W-1:0]       dec_lat,
    input  logic [LANES*PAYLOAD_W-1:0]   dec_payload,
    output logic [LANES-1:0]             dec_accept,
    input  logic                         flush,
    output logic                         dep_stall,
    output logic [LANES-1:0]             iss_valid,
    output logic [LANES*3*ADDR_W-1:0]    iss_src_addr,
    output logic [LANES*ADDR_W-1:0]      iss_rt_addr,
    output logic [LANES-1:0]             iss_rt_wr,
    output logic [LANES*PAYLOAD_W-1:0]   iss_payload
);

    logic [LAT_W-1:0]  pend     [NUM_REGS];
    logic [LAT_W-1:0]  pend_nxt [NUM_REGS];
    logic [ADDR_W-1:0] src_a    [LANES][3];
    logic [ADDR_W-1:0] rt_a     [LANES];
    logic [LAT_W-1:0]  lat_a    [LANES];
    logic [LANES-1:0]  accept;
    logic              in_order;
    logic              rdy;

    for (genvar k = 0; k < LANES; k++) begin : g_unpack
        for (genvar s = 0; s < 3; s++) begin : g_src
            assign src_a[k][s] = dec_src_addr[(k*3+s)*ADDR_W +: ADDR_W];
        end
        assign rt_a[k]  = dec_rt_addr[k*ADDR_W +: ADDR_W];
        assign lat_a[k] = dec_lat[k*LAT_W +: LAT_W];
    end

    // A count of 1 means the writer leaves on this edge: already forwardable.
    always_comb begin
        accept   = '0;
        in_order = !flush;
        rdy      = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            rdy = 1'b1;
            for (int s = 0; s < 3; s++) begin
                if (dec_src_used[k*3+s] && pend[src_a[k][s]] > LAT_W'(1))
                    rdy = 1'b0;
            end
            for (int i = 0; i < k; i++) begin
                if (accept[i] && dec_rt_wr[i]) begin
                    for (int s = 0; s < 3; s++) begin
                        if (dec_src_used[k*3+s] && src_a[k][s] == rt_a[i])
                            rdy = 1'b0;
                    end
                    if (dec_rt_wr[k] && rt_a[k] == rt_a[i])
                        rdy = 1'b0;
                end
            end
            accept[k] = in_order && dec_valid[k] && rdy;
            if (dec_valid[k] && !accept[k])
                in_order = 1'b0;
        end
    end

    assign dec_accept = accept;
    assign dep_stall  = !flush && |(dec_valid & ~accept);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            pend_nxt[r] = (pend[r] != '0) ? pend[r] - LAT_W'(1) : '0;
        for (int k = 0; k < LANES; k++) begin
            if (accept[k] && dec_rt_wr[k] && lat_a[k] > pend_nxt[rt_a[k]])
                pend_nxt[rt_a[k]] = lat_a[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                pend[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                pend[r] <= pend_nxt[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid    <= '0;
            iss_src_addr <= '0;
            iss_rt_addr  <= '0;
            iss_rt_wr    <= '0;
            iss_payload  <= '0;
        end else begin
            iss_valid <= accept;
            for (int k = 0; k < LANES; k++) begin
                if (accept[k]) begin
                    iss_src_addr[k*3*ADDR_W +: 3*ADDR_W] <=
                        dec_src_addr[k*3*ADDR_W +: 3*ADDR_W];
                    iss_rt_addr[k*ADDR_W +: ADDR_W] <=
                        dec_rt_addr[k*ADDR_W +: ADDR_W];
                    iss_rt_wr[k] <= dec_rt_wr[k];
                    iss_payload[k*PAYLOAD_W +: PAYLOAD_W] <=
                        dec_payload[k*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed hazard scenarios plus a random stream
// checked against a model that tracks the absolute cycle each register is ready.
module tb_issue_scoreboard;

    localparam int LANES     = 4;
    localparam int NUM_REGS  = 128;
    localparam int ADDR_W    = 7;
    localparam int LAT_W     = 4;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [2:0]             used;
        logic [2:0][ADDR_W-1:0] src;
        logic [ADDR_W-1:0]      rt;
        logic                   wr;
        logic [LAT_W-1:0]       lat;
        logic [PAYLOAD_W-1:0]   pl;
    } instr_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic [LANES-1:0]           dec_valid;
    logic [LANES*3*ADDR_W-1:0]  dec_src_addr;
    logic [LANES*3-1:0]         dec_src_used;
    logic [LANES*ADDR_W-1:0]    dec_rt_addr;
    logic [LANES-1:0]           dec_rt_wr;
    logic [LANES*LAT_W-1:0]     dec_lat;
    logic [LANES*PAYLOAD_W-1:0] dec_payload;
    logic [LANES-1:0]           dec_accept;
    logic                       dep_stall;
    logic [LANES-1:0]           iss_valid;
    logic [LANES*3*ADDR_W-1:0]  iss_src_addr;
    logic [LANES*ADDR_W-1:0]    iss_rt_addr;
    logic [LANES-1:0]           iss_rt_wr;
    logic [LANES*PAYLOAD_W-1:0] iss_payload;

    issue_scoreboard #(
        .LANES(LANES), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .LAT_W(LAT_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_src_addr(dec_src_addr),
        .dec_src_used(dec_src_used), .dec_rt_addr(dec_rt_addr),
        .dec_rt_wr(dec_rt_wr), .dec_lat(dec_lat),
        .dec_payload(dec_payload), .dec_accept(dec_accept),
        .flush(flush), .dep_stall(dep_stall),
        .iss_valid(iss_valid), .iss_src_addr(iss_src_addr),
        .iss_rt_addr(iss_rt_addr), .iss_rt_wr(iss_rt_wr),
        .iss_payload(iss_payload)
    );

    always #5 clk = ~clk;

    instr_t           lane [LANES];
    logic [LANES-1:0] lv;

    always_comb begin
        dec_valid    = '0;
        dec_src_addr = '0;
        dec_src_used = '0;
        dec_rt_addr  = '0;
        dec_rt_wr    = '0;
        dec_lat      = '0;
        dec_payload  = '0;
        for (int k = 0; k < LANES; k++) begin
            dec_valid[k] = lv[k];
            dec_src_addr[k*3*ADDR_W +: 3*ADDR_W] = lane[k].src;
            dec_src_used[k*3 +: 3] = lane[k].used;
            dec_rt_addr[k*ADDR_W +: ADDR_W] = lane[k].rt;
            dec_rt_wr[k] = lane[k].wr;
            dec_lat[k*LAT_W +: LAT_W] = lane[k].lat;
            dec_payload[k*PAYLOAD_W +: PAYLOAD_W] = lane[k].pl;
        end
    end

    // Model: avail[r] = first cycle a reader of r may be accepted.
    int               avail [NUM_REGS];
    int               cyc;
    logic [LANES-1:0] m_acc;
    logic             m_stall;
    logic [LANES-1:0] e_valid;
    instr_t           e_ins [LANES];
    int               vectors;
    int               miscompares;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) avail[r] = 0;
        e_valid = '0;
        for (int k = 0; k < LANES; k++) e_ins[k] = '0;
    endtask

    task automatic model_comb();
        logic ok;
        logic r;
        m_acc = '0;
        ok = !flush;
        for (int k = 0; k < LANES; k++) begin
            r = 1'b1;
            for (int s = 0; s < 3; s++)
                if (lane[k].used[s] && avail[lane[k].src[s]] > cyc) r = 1'b0;
            for (int i = 0; i < k; i++) begin
                if (m_acc[i] && lane[i].wr) begin
                    for (int s = 0; s < 3; s++)
                        if (lane[k].used[s] && lane[k].src[s] == lane[i].rt)
                            r = 1'b0;
                    if (lane[k].wr && lane[k].rt == lane[i].rt) r = 1'b0;
                end
            end
            if (ok && lv[k] && r) m_acc[k] = 1'b1;
            else if (lv[k]) ok = 1'b0;
        end
        m_stall = !flush && |(lv & ~m_acc);
    endtask

    task automatic cycle_check();
        @(negedge clk);
        model_comb();
        chk("dec_accept", 64'(dec_accept), 64'(m_acc));
        chk("dep_stall", 64'(dep_stall), 64'(m_stall));
        chk("iss_valid", 64'(iss_valid), 64'(e_valid));
        for (int k = 0; k < LANES; k++) begin
            if (e_valid[k]) begin
                chk("iss_src", 64'(iss_src_addr[k*3*ADDR_W +: 3*ADDR_W]),
                    64'(e_ins[k].src));
                chk("iss_rt", 64'(iss_rt_addr[k*ADDR_W +: ADDR_W]),
                    64'(e_ins[k].rt));
                chk("iss_wr", 64'(iss_rt_wr[k]), 64'(e_ins[k].wr));
                chk("iss_pl", 64'(iss_payload[k*PAYLOAD_W +: PAYLOAD_W]),
                    64'(e_ins[k].pl));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (m_acc[k]) begin
                    if (lane[k].wr && avail[lane[k].rt] < cyc + int'(lane[k].lat))
                        avail[lane[k].rt] = cyc + int'(lane[k].lat);
                    e_ins[k] = lane[k];
                end
            end
            e_valid = m_acc;
        end
        cyc++;
        #1;
    endtask

    task automatic clear_lanes();
        lv = '0;
        for (int k = 0; k < LANES; k++) lane[k] = '0;
    endtask

    task automatic set_lane(input int k, input int s0, input int s1,
                            input int s2, input logic [2:0] used,
                            input int rt, input logic wr, input int lat);
        lv[k] = 1'b1;
        lane[k].used = used;
        lane[k].src[0] = ADDR_W'(s0);
        lane[k].src[1] = ADDR_W'(s1);
        lane[k].src[2] = ADDR_W'(s2);
        lane[k].rt = ADDR_W'(rt);
        lane[k].wr = wr;
        lane[k].lat = LAT_W'(lat);
        lane[k].pl = PAYLOAD_W'($urandom);
    endtask

    task automatic idle(input int n);
        clear_lanes();
        repeat (n) begin
            cycle_check();
            advance();
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t x;
        x.used = 3'($urandom);
        for (int s = 0; s < 3; s++) x.src[s] = ADDR_W'($urandom_range(0, 15));
        x.rt = ADDR_W'($urandom_range(0, 15));
        x.wr = 1'($urandom);
        if ($urandom_range(0, 3) == 0)
            x.lat = LAT_W'($urandom_range(1, 2**LAT_W - 1));
        else
            x.lat = LAT_W'($urandom_range(1, 3));
        x.pl = PAYLOAD_W'($urandom);
        return x;
    endfunction

    instr_t q[$];
    instr_t tmp;
    int     n;

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst = 1'b1;
        flush = 1'b0;
        clear_lanes();
        model_reset();
        m_acc = '0;
        repeat (2) begin
            cycle_check();
            advance();
        end
        rst = 1'b0;

        // latency countdown: r5 L=3 at cycle t, reader accepted at t+3
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 5, 1'b1, 3);
        cycle_check();
        chk("lat_writer", 64'(dec_accept), 64'h1);
        advance();
        clear_lanes();
        set_lane(0, 5, 0, 0, 3'b001, 20, 1'b1, 1);
        for (int c = 1; c <= 3; c++) begin
            cycle_check();
            if (c < 3) chk("lat_stall", 64'(dep_stall), 64'h1);
            else chk("lat_accept", 64'(dec_accept), 64'h1);
            advance();
        end
        idle(16);

        // intra-bundle RAW on r9
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 9, 1'b1, 2);
        set_lane(1, 1, 9, 2, 3'b010, 21, 1'b1, 1);
        cycle_check();
        chk("raw_bundle", 64'(dec_accept), 64'h1);
        advance();
        tmp = lane[1];
        clear_lanes();
        lane[0] = tmp;
        lv[0] = 1'b1;
        cycle_check();
        chk("raw_restall", 64'(dep_stall), 64'h1);
        advance();
        cycle_check();
        chk("raw_release", 64'(dec_accept), 64'h1);
        advance();
        idle(16);

        // in-order blocking behind pending r3
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 3, 1'b1, 4);
        cycle_check();
        advance();
        clear_lanes();
        set_lane(0, 3, 0, 0, 3'b001, 22, 1'b1, 1);
        set_lane(1, 30, 31, 0, 3'b011, 23, 1'b1, 1);
        cycle_check();
        chk("blk_accept", 64'(dec_accept), 64'h0);
        chk("blk_stall", 64'(dep_stall), 64'h1);
        advance();
        idle(16);

        // flush does not clear pend: r7 L=5 reader still waits until t+5
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 7, 1'b1, 5);
        cycle_check();
        advance();
        clear_lanes();
        set_lane(0, 7, 0, 0, 3'b001, 24, 1'b1, 1);
        set_lane(1, 40, 0, 0, 3'b001, 25, 1'b1, 2);
        flush = 1'b1;
        cycle_check();
        chk("fl_accept", 64'(dec_accept), 64'h0);
        chk("fl_stall", 64'(dep_stall), 64'h0);
        advance();
        flush = 1'b0;
        cycle_check();
        chk("fl_iss", 64'(iss_valid), 64'h0);
        n = 2;
        while (!dec_accept[0] && n < 20) begin
            advance();
            cycle_check();
            n++;
        end
        chk("fl_wait", 64'(n), 64'd5);
        advance();
        idle(16);

        // cross-bundle WAW: r7 L=6 then r7 L=2 keeps the longer count
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 7, 1'b1, 6);
        cycle_check();
        advance();
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 7, 1'b1, 2);
        cycle_check();
        chk("waw_second", 64'(dec_accept), 64'h1);
        advance();
        clear_lanes();
        set_lane(0, 7, 0, 0, 3'b001, 26, 1'b0, 0);
        n = 2;
        cycle_check();
        while (!dec_accept[0] && n < 20) begin
            advance();
            cycle_check();
            n++;
        end
        chk("waw_wait", 64'(n), 64'd6);
        advance();
        idle(16);

        // intra-bundle WAW
        clear_lanes();
        set_lane(0, 0, 0, 0, 3'b000, 7, 1'b1, 1);
        set_lane(1, 0, 0, 0, 3'b000, 7, 1'b1, 1);
        cycle_check();
        chk("waw_bundle", 64'(dec_accept), 64'h1);
        advance();
        idle(16);

        // async reset with a valid bundle held
        clear_lanes();
        set_lane(0, 1, 2, 0, 3'b011, 50, 1'b1, 7);
        set_lane(1, 0, 0, 0, 3'b000, 51, 1'b1, 7);
        cycle_check();
        chk("rst_pre", 64'(dec_accept), 64'h3);
        advance();
        clear_lanes();
        set_lane(0, 50, 0, 0, 3'b001, 52, 1'b1, 1);
        set_lane(1, 51, 0, 0, 3'b001, 53, 1'b1, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_iss", 64'(iss_valid), 64'h0);
        model_reset();
        cycle_check();
        chk("rst_accept", 64'(dec_accept), 64'h3);
        advance();
        rst = 1'b0;
        cycle_check();
        chk("rel_accept", 64'(dec_accept), 64'h3);
        advance();
        cycle_check();
        chk("rel_iss", 64'(iss_valid), 64'h3);
        advance();
        idle(16);

        // random legal stream: upstream re-presents refused lanes in order
        for (int t = 0; t < 4000; t++) begin
            while (q.size() < LANES) q.push_back(rand_instr());
            flush = ($urandom_range(0, 15) == 0);
            clear_lanes();
            n = $urandom_range(0, LANES);
            for (int k = 0; k < n; k++) begin
                lane[k] = q[k];
                lv[k] = 1'b1;
            end
            cycle_check();
            advance();
            repeat ($countones(m_acc)) void'(q.pop_front());
        end
        flush = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
